// File: rtl/mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage: pipeline MEM stage, variable-latency data access with sticky error
// Revision: 1.0
// ---------------------------------------------------------------------------
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] aluResIn,
  input  logic [15:0] memWriteDataIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        HaltIn,
  input  logic [15:0] memDataIn,
  input  logic        memDone,
  output logic [15:0] memAddr,
  output logic [15:0] memDataOut,
  output logic        memRd,
  output logic        memWr,
  output logic [15:0] readDataOut,
  output logic        memStall,
  output logic        errOut,
  output logic        haltOut
);

  localparam logic [1:0]       S_IDLE = 2'd0;
  localparam logic [1:0]       S_BUSY = 2'd1;
  localparam logic [1:0]       S_ERR  = 2'd2;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic             is_wr_q, is_wr_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic req;
  logic bad;

  assign req = MemReadIn | MemWriteIn;
  assign bad = (MemReadIn & MemWriteIn) | (req & aluResIn[0]);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    is_wr_d     = is_wr_q;
    wait_cnt_d  = wait_cnt_q;
    memAddr     = addr_q;
    memDataOut  = data_q;
    memRd       = 1'b0;
    memWr       = 1'b0;
    memStall    = 1'b0;
    readDataOut = 16'h0000;
    errOut      = 1'b0;
    haltOut     = 1'b0;

    case (state_q)
      S_IDLE: begin
        memAddr    = aluResIn;
        memDataOut = memWriteDataIn;
        memRd      = MemReadIn & ~bad;
        memWr      = MemWriteIn & ~bad;
        haltOut    = HaltIn & ~bad;
        if (bad) begin
          state_d = S_ERR;
          errOut  = 1'b1;
        end else if (req) begin
          if (memDone) begin
            if (MemReadIn) readDataOut = memDataIn;
          end else begin
            state_d    = S_BUSY;
            addr_d     = aluResIn;
            data_d     = memWriteDataIn;
            is_wr_d    = MemWriteIn;
            wait_cnt_d = CNT_W'(1);
            memStall   = 1'b1;
          end
        end
      end

      S_BUSY: begin
        memRd = ~is_wr_q;
        memWr = is_wr_q;
        if (memDone) begin
          state_d = S_IDLE;
          if (!is_wr_q) readDataOut = memDataIn;
        end else begin
          memStall = 1'b1;
          // >= rather than == keeps TIMEOUT=1 from waiting forever
          if (wait_cnt_q >= C_LAST) state_d = S_ERR;
          else wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        memStall = 1'b1;
        errOut   = 1'b1;
      end
    endcase

    if (rst) begin
      memRd       = 1'b0;
      memWr       = 1'b0;
      memStall    = 1'b0;
      errOut      = 1'b0;
      haltOut     = 1'b0;
      readDataOut = 16'h0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'h0000;
      data_q     <= 16'h0000;
      is_wr_q    <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      is_wr_q    <= is_wr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_stage: randomized scoreboard bench for mem_stage
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mem_stage;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] aluResIn, memWriteDataIn, memDataIn;
  logic        MemReadIn, MemWriteIn, HaltIn, memDone;
  logic [15:0] memAddr, memDataOut, readDataOut;
  logic        memRd, memWr, memStall, errOut, haltOut;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .aluResIn(aluResIn), .memWriteDataIn(memWriteDataIn),
    .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .HaltIn(HaltIn),
    .memDataIn(memDataIn), .memDone(memDone),
    .memAddr(memAddr), .memDataOut(memDataOut),
    .memRd(memRd), .memWr(memWr), .readDataOut(readDataOut),
    .memStall(memStall), .errOut(errOut), .haltOut(haltOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          is_wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          strobes;
    int          stalls;
  } exp_t;

  exp_t        sbq[$];
  logic [15:0] mdl[logic [15:0]];  // reference view of memory contents
  logic [15:0] dev[logic [15:0]];  // the memory device the DUT talks to
  int n_total = 0;
  int n_bad   = 0;

  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Monitor: pops an expectation on every completion or error onset
  int   strobe_cnt = 0;
  int   stall_cnt  = 0;
  bit   err_prev   = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outputs", {memRd, memWr, memStall, errOut, haltOut, readDataOut}, 0);
      strobe_cnt = 0;
      stall_cnt  = 0;
      err_prev   = 1'b0;
    end else begin
      if (memRd | memWr) strobe_cnt++;
      if (memStall && !errOut) stall_cnt++;
      if ((memRd | memWr) && memDone) begin
        if (sbq.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("cpl_is_err", errOut, mon_e.is_err);
          chk("cpl_wr", memWr, mon_e.is_wr);
          chk("cpl_addr", memAddr, mon_e.addr);
          if (mon_e.is_wr) chk("cpl_wdata", memDataOut, mon_e.wdata);
          chk("cpl_rdata", readDataOut, mon_e.rdata);
          chk("cpl_strobes", strobe_cnt, mon_e.strobes);
          chk("cpl_stalls", stall_cnt, mon_e.stalls);
        end
        strobe_cnt = 0;
        stall_cnt  = 0;
      end else begin
        chk("rdata_quiet", readDataOut, 0);
      end
      if (errOut && !err_prev) begin
        if (sbq.size() == 0) begin
          chk("unexpected_error", 1, 0);
        end else begin
          mon_e = sbq.pop_front();
          chk("err_kind", errOut, mon_e.is_err);
          chk("err_strobes", strobe_cnt, mon_e.strobes);
        end
        strobe_cnt = 0;
        stall_cnt  = 0;
      end
      if (errOut && err_prev) chk("err_hold", {memStall, memRd, memWr}, 3'b100);
      err_prev = errOut;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemReadIn      = 1'b0;
    MemWriteIn     = 1'b0;
    HaltIn         = 1'b0;
    memDone        = 1'b0;
    aluResIn       = 16'($urandom);
    memWriteDataIn = 16'($urandom);
    memDataIn      = 16'($urandom);
  endtask

  task automatic rand_inputs();
    MemReadIn      = 1'($urandom);
    MemWriteIn     = 1'($urandom);
    HaltIn         = 1'($urandom);
    aluResIn       = 16'($urandom);
    memWriteDataIn = 16'($urandom);
  endtask

  // Memory device: answers whatever the DUT is strobing this cycle
  task automatic mem_respond();
    #1;
    if (memDone && (memRd | memWr)) begin
      if (memWr) dev[memAddr] = memDataOut;
      else memDataIn = dev.exists(memAddr) ? dev[memAddr] : dflt(memAddr);
    end else begin
      memDataIn = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic idle_cycle();
    idle_inputs();
    HaltIn  = 1'($urandom);
    memDone = 1'($urandom);
    #1;
    chk("halt_idle", haltOut, HaltIn);
    chk("stall_idle", memStall, 0);
    step();
  endtask

  // wt = cycles after issue until memDone; wt >= TIMEOUT means memory never answers
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] data, input int wt);
    exp_t e;
    bit   isbad;
    int   last;
    isbad = (rd & wr) | ((rd | wr) & addr[0]);
    e = '{default: 0};
    e.addr  = addr;
    e.is_wr = wr;
    e.wdata = data;
    if (isbad) begin
      e.is_err = 1'b1;
    end else if (wt >= TIMEOUT) begin
      e.is_err  = 1'b1;
      e.strobes = TIMEOUT;
    end else begin
      e.strobes = wt + 1;
      e.stalls  = wt;
      if (wr) mdl[addr] = data;
      else e.rdata = mdl.exists(addr) ? mdl[addr] : dflt(addr);
    end
    sbq.push_back(e);

    MemReadIn      = rd;
    MemWriteIn     = wr;
    aluResIn       = addr;
    memWriteDataIn = data;
    HaltIn         = 1'($urandom);
    memDone        = (wt == 0);
    mem_respond();
    step();

    if (isbad) begin
      for (int k = 0; k < 3; k++) begin
        rand_inputs();
        HaltIn  = 1'b1;
        memDone = 1'($urandom);
        mem_respond();
        chk("halt_in_err", haltOut, 0);
        step();
      end
      do_reset();
    end else begin
      last = (wt < TIMEOUT) ? wt : TIMEOUT + 2;
      for (int k = 1; k <= last; k++) begin
        rand_inputs();
        memDone = (k == wt);
        mem_respond();
        step();
      end
      idle_inputs();
      if (wt >= TIMEOUT) do_reset();
    end
  endtask

  task automatic reset_mid_busy();
    idle_inputs();
    MemReadIn = 1'b1;
    aluResIn  = 16'h0010;
    mem_respond();
    step();
    for (int k = 0; k < 2; k++) begin
      rand_inputs();
      memDone = 1'b0;
      mem_respond();
      step();
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rand_inputs();
      memDone = 1'b1;
      mem_respond();
      step();
    end
    rst = 1'b0;
    idle_inputs();
    HaltIn = 1'b1;
    #1;
    chk("halt_after_rst", haltOut, 1);
    chk("stall_after_rst", memStall, 0);
    step();
    idle_inputs();
  endtask

  initial begin
    int r, wt;
    bit rd, wr;
    logic [15:0] a;
    idle_inputs();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("reset_state", {memRd, memWr, memStall, errOut, haltOut, readDataOut}, 0);
    step();

    dev[16'h0040] = 16'hBEEF;
    mdl[16'h0040] = 16'hBEEF;
    access(1'b1, 1'b0, 16'h0040, 16'h0000, 0);
    idle_cycle();
    access(1'b0, 1'b1, 16'h0102, 16'h1234, 3);
    idle_cycle();
    access(1'b1, 1'b0, 16'h0102, 16'h0000, 1);
    access(1'b1, 1'b0, 16'h0033, 16'h0000, 0);
    access(1'b1, 1'b1, 16'h0020, 16'h0000, 0);
    access(1'b1, 1'b0, 16'h0044, 16'h0000, NEVER);
    access(1'b1, 1'b0, 16'h0046, 16'h0000, TIMEOUT - 1);
    access(1'b0, 1'b1, 16'h0048, 16'hA5A5, TIMEOUT);
    reset_mid_busy();

    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 99);
      rd = 1'($urandom);
      wr = ~rd;
      a  = {10'h000, 5'($urandom), 1'b0};
      wt = ($urandom_range(0, 7) == 0) ? TIMEOUT - 1 : $urandom_range(0, 4);
      if (r < 4) begin
        rd = 1'b1;
        wr = 1'b1;
      end else if (r < 8) begin
        a[0] = 1'b1;
      end else if (r < 12) begin
        wt = NEVER;
      end
      access(rd, wr, a, 16'($urandom), wt);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    repeat (2) idle_cycle();
    chk("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
